// File: rtl/ledsuit_pkg.sv
// Shared definitions for the ledsuit frame-memory path.
// Bus width defaults and read-return tag encoding.
package ledsuit_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 13;
    localparam int DEFAULT_DATA_WIDTH    = 8;

    localparam logic REQ_SPI = 1'b0;
    localparam logic REQ_LED = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/bram_arb_rd_pipe.sv
// Two-stage read tag shift register.
// Stage 2 lines up with the BRAM read data.
import ledsuit_pkg::*;

module bram_arb_rd_pipe (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage1;
    rd_tag_t stage2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1 <= '0;
            stage2 <= '0;
        end else begin
            stage1 <= tag_in;
            stage2 <= stage1;
        end
    end

    assign tag_out = stage2;

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for one single-port frame BRAM.
// Fixed priority to the SPI side with a starvation guard for the LED side.
import ledsuit_pkg::*;

module bram_port_arbiter #(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int MAX_R0_RUN    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r0_req,
    input  logic                     r0_we,
    input  logic [ADDRESS_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0]    r0_din,
    output logic                     r0_gnt,
    output logic                     r0_rvalid,
    output logic [DATA_WIDTH-1:0]    r0_dout,
    input  logic                     r1_req,
    input  logic [ADDRESS_WIDTH-1:0] r1_addr,
    output logic                     r1_gnt,
    output logic                     r1_rvalid,
    output logic [DATA_WIDTH-1:0]    r1_dout,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_din,
    input  logic [DATA_WIDTH-1:0]    mem_dout
);

    localparam logic [3:0] RUN_LIMIT = 4'(MAX_R0_RUN);

    logic [3:0] run_cnt;
    logic       run_full;
    rd_tag_t    tag_in;
    rd_tag_t    tag_out;

    assign run_full = (run_cnt == RUN_LIMIT);

    // r1 takes the port when r0 is idle or r0 has used up its run.
    assign r1_gnt = r1_req & (~r0_req | run_full);
    assign r0_gnt = r0_req & ~r1_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (!r1_req || r1_gnt) begin
            run_cnt <= '0;
        end else if (r0_gnt && !run_full) begin
            run_cnt <= run_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (r0_gnt) begin
            mem_we   <= r0_we;
            mem_addr <= r0_addr;
            mem_din  <= r0_din;
        end else if (r1_gnt) begin
            mem_we   <= 1'b0;
            mem_addr <= r1_addr;
        end else begin
            mem_we   <= 1'b0;
        end
    end

    assign tag_in.valid = (r0_gnt & ~r0_we) | r1_gnt;
    assign tag_in.id    = r1_gnt ? REQ_LED : REQ_SPI;

    bram_arb_rd_pipe u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign r0_rvalid = tag_out.valid & (tag_out.id == REQ_SPI);
    assign r1_rvalid = tag_out.valid & (tag_out.id == REQ_LED);
    assign r0_dout   = mem_dout;
    assign r1_dout   = mem_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural BRAM.
// Unwritten BRAM words read as addr[7:0] ^ 8'h3C.
module tb_bram_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_req = 1'b0;
    logic          r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_din = '0;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [DW-1:0] r0_dout;
    logic          r1_req = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [DW-1:0] r1_dout;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .MAX_R0_RUN    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_din    (r0_din),
        .r0_gnt    (r0_gnt),
        .r0_rvalid (r0_rvalid),
        .r0_dout   (r0_dout),
        .r1_req    (r1_req),
        .r1_addr   (r1_addr),
        .r1_gnt    (r1_gnt),
        .r1_rvalid (r1_rvalid),
        .r1_dout   (r1_dout),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    logic [DW-1:0]     ram [0:(1<<AW)-1];
    logic [(1<<AW)-1:0] wr_mask;

    always @(posedge clk) begin
        if (rst) begin
            wr_mask <= '0;
        end else if (mem_we) begin
            ram[mem_addr]     <= mem_din;
            wr_mask[mem_addr] <= 1'b1;
        end
        mem_dout <= wr_mask[mem_addr] ? ram[mem_addr]
                                      : (mem_addr[7:0] ^ 8'h3C);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_ctrl got=%b exp=00000",
                     {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we});
        end
        n_checks++;
        if (mem_addr !== 13'h0 || mem_din !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_bus got addr=%h din=%h exp 0/0", mem_addr, mem_din);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 13'h0010;
        @(negedge clk);
        n_checks++;
        if (r0_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_gnt got=%b exp=1", r0_gnt);
        end
        next_cycle();
        r0_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_we, mem_addr, r0_rvalid, r1_rvalid} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid got we=%b addr=%h rv=%b%b exp zeros",
                     mem_we, mem_addr, r0_rvalid, r1_rvalid);
        end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_no_rvalid cyc=%0d got=%b%b exp=00",
                         i, r0_rvalid, r1_rvalid);
            end
            next_cycle();
        end
    endtask

    task automatic test_r0_alone();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 13'h0123; r0_din = 8'hA5;
        @(negedge clk);
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL r0_wr_gnt got=%b%b exp=10", r0_gnt, r1_gnt);
        end
        next_cycle();
        r0_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (r0_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL r0_rd_gnt got=%b exp=1", r0_gnt);
        end
        n_checks++;
        if ({mem_we, mem_addr, mem_din} !== {1'b1, 13'h0123, 8'hA5}) begin
            n_fail++;
            $display("FAIL r0_wr_issue got we=%b addr=%h din=%h exp 1/0123/a5",
                     mem_we, mem_addr, mem_din);
        end
        next_cycle();
        r0_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_we, mem_addr, r0_rvalid} !== {1'b0, 13'h0123, 1'b0}) begin
            n_fail++;
            $display("FAIL r0_rd_issue got we=%b addr=%h rv=%b exp 0/0123/0",
                     mem_we, mem_addr, r0_rvalid);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({r0_rvalid, r1_rvalid, r0_dout} !== {2'b10, 8'hA5}) begin
            n_fail++;
            $display("FAIL r0_raw got rv=%b%b dout=%h exp 10/a5",
                     r0_rvalid, r1_rvalid, r0_dout);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (r0_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_rv_pulse got=%b exp=0", r0_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_r1_alone();
        r1_req = 1'b1; r1_addr = 13'h1FFE;
        @(negedge clk);
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL r1_gnt_a got=%b%b exp=01", r0_gnt, r1_gnt);
        end
        next_cycle();
        r1_addr = 13'h1FFF;
        @(negedge clk);
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL r1_gnt_b got=%b%b exp=01", r0_gnt, r1_gnt);
        end
        n_checks++;
        if ({mem_we, mem_addr, mem_din} !== {1'b0, 13'h1FFE, 8'hA5}) begin
            n_fail++;
            $display("FAIL r1_issue_a got we=%b addr=%h din=%h exp 0/1ffe/a5",
                     mem_we, mem_addr, mem_din);
        end
        next_cycle();
        r1_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_we, mem_addr} !== {1'b0, 13'h1FFF}) begin
            n_fail++;
            $display("FAIL r1_issue_b got we=%b addr=%h exp 0/1fff", mem_we, mem_addr);
        end
        n_checks++;
        if ({r0_rvalid, r1_rvalid, r1_dout} !== {2'b01, 8'hC2}) begin
            n_fail++;
            $display("FAIL r1_ret_a got rv=%b%b dout=%h exp 01/c2",
                     r0_rvalid, r1_rvalid, r1_dout);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({r0_rvalid, r1_rvalid, r1_dout} !== {2'b01, 8'hC3}) begin
            n_fail++;
            $display("FAIL r1_ret_b got rv=%b%b dout=%h exp 01/c3",
                     r0_rvalid, r1_rvalid, r1_dout);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (r1_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL r1_rv_end got=%b exp=0", r1_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        int k = 0;
        int j = 0;
        for (int i = 0; i < 14; i++) begin
            logic exp_g1;
            logic exp_g0;
            logic [1:0] exp_rv;
            logic [DW-1:0] exp_d;
            r0_req = (i < 12); r1_req = (i < 12); r0_we = 1'b0;
            r0_addr = 13'h0100 + 13'(k);
            r1_addr = 13'h02C0 + 13'(j);
            exp_g1 = (i < 12) && (i % 5 == 4);
            exp_g0 = (i < 12) && !exp_g1;
            exp_rv = 2'b00;
            exp_d = 8'h00;
            if (i >= 2) begin
                if ((i - 2) % 5 == 4) begin
                    exp_rv = 2'b01;
                    exp_d = 8'hFC + 8'((i - 2) / 5);
                end else begin
                    exp_rv = 2'b10;
                    exp_d = 8'((i - 2) - (i - 2) / 5) ^ 8'h3C;
                end
            end
            @(negedge clk);
            n_checks++;
            if ({r0_gnt, r1_gnt} !== {exp_g0, exp_g1}) begin
                n_fail++;
                $display("FAIL starve_gnt cyc=%0d got=%b%b exp=%b%b",
                         i, r0_gnt, r1_gnt, exp_g0, exp_g1);
            end
            n_checks++;
            if ({r0_rvalid, r1_rvalid} !== exp_rv ||
                (exp_rv == 2'b10 && r0_dout !== exp_d) ||
                (exp_rv == 2'b01 && r1_dout !== exp_d)) begin
                n_fail++;
                $display("FAIL starve_ret cyc=%0d got rv=%b%b d=%h exp rv=%b d=%h",
                         i, r0_rvalid, r1_rvalid, mem_dout, exp_rv, exp_d);
            end
            if (exp_g0) k++;
            if (exp_g1) j++;
            next_cycle();
        end
    endtask

    task automatic test_priority_free_r1();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 13'h0041;
        r1_req = 1'b1; r1_addr = 13'h0040;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({r0_gnt, r1_gnt} !== 2'b10) begin
                n_fail++;
                $display("FAIL prio_r0 cyc=%0d got=%b%b exp=10", i, r0_gnt, r1_gnt);
            end
            next_cycle();
        end
        r0_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL prio_r1_free got=%b%b exp=01", r0_gnt, r1_gnt);
        end
        next_cycle();
        r1_req = 1'b0;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({r0_rvalid, r1_rvalid, r1_dout} !== {2'b01, 8'h7C}) begin
            n_fail++;
            $display("FAIL prio_r1_ret got rv=%b%b dout=%h exp 01/7c",
                     r0_rvalid, r1_rvalid, r1_dout);
        end
        next_cycle();
    endtask

    task automatic test_withdrawal();
        r0_we = 1'b0; r0_addr = 13'h0050; r1_addr = 13'h0060;
        for (int i = 0; i < 10; i++) begin
            logic exp_g1;
            logic exp_g0;
            r0_req = (i < 7);
            r1_req = (i == 0) || (i >= 2 && i < 7);
            exp_g1 = (i == 6);
            exp_g0 = (i < 7) && !exp_g1;
            @(negedge clk);
            n_checks++;
            if ({r0_gnt, r1_gnt} !== {exp_g0, exp_g1}) begin
                n_fail++;
                $display("FAIL wd_gnt cyc=%0d got=%b%b exp=%b%b",
                         i, r0_gnt, r1_gnt, exp_g0, exp_g1);
            end
            n_checks++;
            if (r1_rvalid !== (i == 8)) begin
                n_fail++;
                $display("FAIL wd_r1_rvalid cyc=%0d got=%b exp=%b",
                         i, r1_rvalid, (i == 8));
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_r0_alone();
        test_r1_alone();
        test_starvation();
        test_priority_free_r1();
        test_withdrawal();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
